vga_pmod_rx: RTL and testbench

Receive-side decoder for the TinyVGA PMOD byte produced by the video generator. It samples the 8-bit PMOD bus at pixel clock and recovers hsync/vsync and 2-bit R/G/B. It locks to the 640x480@800x525 timing and emits a coordinate-tagged pixel stream, a per-frame CRC-16 signature and a sync-error count. It sits in the test harness or loopback path, so generator output can be checked on silicon and in simulation without a monitor.

---
 rtl/vga_pmod_rx.sv | 162 ++++++++++++++++
 tb/tb_vga_pmod_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pmod_rx.sv
// rtl/vga_pmod_rx.sv - TinyVGA PMOD receive decoder with timing lock, pixel stream and frame CRC
// Two-cycle fixed pipeline: stage-1 capture, then counter/FSM/output update.
module vga_pmod_rx #(
  parameter int H_ACTIVE        = 640,
  parameter int H_TOTAL         = 800,
  parameter int H_SYNC_START    = 656,
  parameter int V_ACTIVE        = 480,
  parameter int V_TOTAL         = 525,
  parameter int V_SYNC_START    = 490,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pmod_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [1:0]  pix_r,
  output logic [1:0]  pix_g,
  output logic [1:0]  pix_b,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  sync_err_count,
  output logic [15:0] frame_crc,
  output logic        crc_valid
);

  localparam logic [9:0] HA    = 10'(H_ACTIVE);
  localparam logic [9:0] H_LST = 10'(H_TOTAL - 1);
  localparam logic [9:0] HSS   = 10'(H_SYNC_START);
  localparam logic [9:0] VA    = 10'(V_ACTIVE);
  localparam logic [9:0] V_LST = 10'(V_TOTAL - 1);
  localparam logic [9:0] VSS   = 10'(V_SYNC_START);
  // Stage-1 reset value carries inactive syncs so release cannot fake an edge.
  localparam logic [7:0] IDLE  = SYNC_ACTIVE_LOW ? 8'h88 : 8'h00;

  typedef enum logic [1:0] {HUNT, LINE, FRAME, LOCKED} state_t;

  state_t      state, state_nx;
  logic [7:0]  s1;
  logic        hs, vs, hs_prev, vs_prev, hs_edge, vs_edge;
  logic [9:0]  hcnt, vcnt, hcnt_free, vcnt_free, hcnt_nx, vcnt_nx;
  logic        h_wrap, v_step, hs_bad, hs_good, vs_bad;
  logic [1:0]  good_cnt, good_nx;
  logic        err_inc, locked_nx, active_nx, fs_nx, end_nx;
  logic [7:0]  pix_byte;
  logic [15:0] crc;
  logic        frame_ok;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  assign hs       = s1[7] ^ SYNC_ACTIVE_LOW;
  assign vs       = s1[3] ^ SYNC_ACTIVE_LOW;
  assign hs_edge  = hs & ~hs_prev;
  assign vs_edge  = vs & ~vs_prev;
  assign pix_byte = {2'b00, s1[0], s1[4], s1[1], s1[5], s1[2], s1[6]};
  assign pix_x    = hcnt;
  assign pix_y    = vcnt;
  assign locked   = (state == LOCKED);

  always_comb begin
    h_wrap    = (hcnt == H_LST);
    hcnt_free = h_wrap ? 10'd0 : hcnt + 10'd1;
    // An hs load on the wrap sample replaces the wrap, so the line does not advance.
    v_step    = h_wrap && !hs_edge;
    vcnt_free = v_step ? ((vcnt == V_LST) ? 10'd0 : vcnt + 10'd1) : vcnt;
    hcnt_nx   = hs_edge ? HSS : hcnt_free;
    vcnt_nx   = vs_edge ? VSS : vcnt_free;
    hs_good   = hs_edge && (hcnt_free == HSS);
    hs_bad    = hs_edge ? (hcnt_free != HSS) : (hcnt_free == HSS);
    vs_bad    = vs_edge ? (vcnt_free != VSS) : (v_step && (vcnt_free == VSS));
  end

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    err_inc  = 1'b0;
    case (state)
      HUNT: begin
        if (hs_edge) begin
          state_nx = LINE;
          good_nx  = 2'd0;
        end
      end
      LINE: begin
        if (hs_bad) good_nx = 2'd0;
        else if (hs_good && good_cnt != 2'd2) good_nx = good_cnt + 2'd1;
        if (!hs_bad && vs_edge && good_cnt == 2'd2) state_nx = FRAME;
      end
      FRAME: begin
        if (hs_bad) begin
          state_nx = LINE;
          good_nx  = 2'd0;
        end else if (vs_bad) begin
          state_nx = LINE;
        end else if (vs_edge) begin
          state_nx = LOCKED;
        end
      end
      LOCKED: begin
        if (hs_bad || vs_bad) begin
          state_nx = HUNT;
          err_inc  = 1'b1;
        end
      end
      default: state_nx = HUNT;
    endcase
    locked_nx = (state_nx == LOCKED);
    active_nx = locked_nx && (hcnt_nx < HA) && (vcnt_nx < VA);
    fs_nx     = locked_nx && (hcnt_nx == 10'd0) && (vcnt_nx == 10'd0);
    end_nx    = (hcnt_nx == 10'd0) && (vcnt_nx == VA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1             <= IDLE;
      hs_prev        <= 1'b0;
      vs_prev        <= 1'b0;
      hcnt           <= 10'd0;
      vcnt           <= 10'd0;
      state          <= HUNT;
      good_cnt       <= 2'd0;
      pix_valid      <= 1'b0;
      pix_r          <= 2'd0;
      pix_g          <= 2'd0;
      pix_b          <= 2'd0;
      frame_start    <= 1'b0;
      sync_err_count <= 8'd0;
      crc            <= 16'hFFFF;
      frame_ok       <= 1'b0;
      frame_crc      <= 16'd0;
      crc_valid      <= 1'b0;
    end else begin
      s1          <= pmod_in;
      hs_prev     <= hs;
      vs_prev     <= vs;
      hcnt        <= hcnt_nx;
      vcnt        <= vcnt_nx;
      state       <= state_nx;
      good_cnt    <= good_nx;
      pix_valid   <= active_nx;
      pix_r       <= {s1[0], s1[4]};
      pix_g       <= {s1[1], s1[5]};
      pix_b       <= {s1[2], s1[6]};
      frame_start <= fs_nx;
      if (err_inc && sync_err_count != 8'hFF) sync_err_count <= sync_err_count + 8'd1;
      if (fs_nx) crc <= crc16_byte(16'hFFFF, pix_byte);
      else if (active_nx) crc <= crc16_byte(crc, pix_byte);
      // Signature is published only for frames locked from (0,0) through the end of active video.
      if (fs_nx) frame_ok <= 1'b1;
      else if (!locked_nx || end_nx) frame_ok <= 1'b0;
      crc_valid <= end_nx && locked_nx && frame_ok;
      if (end_nx && locked_nx && frame_ok) frame_crc <= crc;
    end
  end

endmodule

// File: tb/tb_vga_pmod_rx.sv
// tb/tb_vga_pmod_rx.sv - scoreboard bench for vga_pmod_rx on a reduced timing grid
// Active-low and active-high instances run side by side on polarity-inverted streams.
module tb_vga_pmod_rx;

  localparam int HA = 8, HT = 12, HSS = 9, HSW = 2;
  localparam int VA = 4, VT = 7, VSS = 5, VSW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pmod_lo, pmod_hi;
  logic        lo_pix_valid, lo_frame_start, lo_locked, lo_crc_valid;
  logic [9:0]  lo_pix_x, lo_pix_y;
  logic [1:0]  lo_pix_r, lo_pix_g, lo_pix_b;
  logic [7:0]  lo_sync_err_count;
  logic [15:0] lo_frame_crc;
  logic        hi_pix_valid, hi_frame_start, hi_locked, hi_crc_valid;
  logic [9:0]  hi_pix_x, hi_pix_y;
  logic [1:0]  hi_pix_r, hi_pix_g, hi_pix_b;
  logic [7:0]  hi_sync_err_count;
  logic [15:0] hi_frame_crc;

  assign pmod_hi = pmod_lo ^ 8'h88;

  vga_pmod_rx #(.H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .V_ACTIVE(VA), .V_TOTAL(VT),
                .V_SYNC_START(VSS), .SYNC_ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .rst_n(rst_n), .pmod_in(pmod_lo), .pix_valid(lo_pix_valid), .pix_x(lo_pix_x),
    .pix_y(lo_pix_y), .pix_r(lo_pix_r), .pix_g(lo_pix_g), .pix_b(lo_pix_b),
    .frame_start(lo_frame_start), .locked(lo_locked), .sync_err_count(lo_sync_err_count),
    .frame_crc(lo_frame_crc), .crc_valid(lo_crc_valid));

  vga_pmod_rx #(.H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .V_ACTIVE(VA), .V_TOTAL(VT),
                .V_SYNC_START(VSS), .SYNC_ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .rst_n(rst_n), .pmod_in(pmod_hi), .pix_valid(hi_pix_valid), .pix_x(hi_pix_x),
    .pix_y(hi_pix_y), .pix_r(hi_pix_r), .pix_g(hi_pix_g), .pix_b(hi_pix_b),
    .frame_start(hi_frame_start), .locked(hi_locked), .sync_err_count(hi_sync_err_count),
    .frame_crc(hi_frame_crc), .crc_valid(hi_crc_valid));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0, passed = 0;
  logic [63:0] pixq[$];
  int          fsq[$], riseq[$], fallq[$];
  logic [15:0] crcq[$], got_crc[$];
  bit          exp_lock = 1'b0, frame_ok = 1'b0, mon_en = 1'b0, lk_prev = 1'b0;
  logic [15:0] mcrc = 16'hFFFF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic unexpected(input string name);
    checks++;
    $display("FAIL %s: got an event, expected none (cycle %0d)", name, cyc);
  endtask

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ b[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // Active-low PMOD byte for colour {R,G,B}: MSBs on bits 0/1/2, LSBs on bits 4/5/6.
  function automatic logic [7:0] enc(input logic [5:0] v, input bit hs_a, input bit vs_a);
    return {~hs_a, v[0], v[2], v[4], ~vs_a, v[1], v[3], v[5]};
  endfunction

  task automatic drive(input logic [5:0] v, input bit hs_a, input bit vs_a, input int ex,
                       input int ey, input bit fall_here, input bit rise_here);
    @(posedge clk);
    #1;
    pmod_lo = enc(v, hs_a, vs_a);
    if (rise_here) begin
      riseq.push_back(cyc + 2);
      exp_lock = 1'b1;
    end
    if (fall_here && exp_lock) begin
      fallq.push_back(cyc + 2);
      exp_lock = 1'b0;
      frame_ok = 1'b0;
    end
    if (exp_lock && ex == 0 && ey == 0) begin
      fsq.push_back(cyc + 2);
      frame_ok = 1'b1;
      mcrc     = 16'hFFFF;
    end
    if (exp_lock && ex < HA && ey < VA) begin
      pixq.push_back({38'd0, 10'(ex), 10'(ey), v});
      mcrc = crc_ref(mcrc, {2'b00, v});
    end
    if (exp_lock && frame_ok && ex == 0 && ey == VA) begin
      crcq.push_back(mcrc);
      frame_ok = 1'b0;
    end
  endtask

  // glitch: one extra clock at the end of line 0 (a 13-clock line); the
  // receiver then sees the sample one position ahead until it drops lock.
  task automatic frame(input bit pat, input bit drop_vs, input bit glitch, input bit rise_f,
                       input int flip_x, input int flip_y);
    logic [5:0] v;
    bit         hs_a, vs_a, fall;
    int         ex;
    for (int gy = 0; gy < VT; gy++) begin
      vs_a = !drop_vs && gy >= VSS && gy < VSS + VSW;
      for (int gx = 0; gx < HT; gx++) begin
        v    = pat ? 6'(gx) : 6'd0;
        if (gx == flip_x && gy == flip_y) v = 6'h3F;
        hs_a = gx >= HSS && gx < HSS + HSW;
        ex   = (glitch && gy == 1) ? gx + 1 : gx;
        fall = (glitch && gy == 1 && ex == HSS) || (drop_vs && gx == 0 && gy == VSS);
        drive(v, hs_a, vs_a, ex, gy, fall, rise_f && gx == 0 && gy == VSS);
      end
      if (glitch && gy == 0) drive(pat ? 6'(HT - 1) : 6'd0, 1'b0, vs_a, 0, 1, 1'b0, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("dual_polarity",
            {10'd0, hi_pix_valid, hi_pix_x, hi_pix_y, hi_pix_r, hi_pix_g, hi_pix_b, hi_frame_start,
             hi_locked, hi_sync_err_count, hi_frame_crc, hi_crc_valid},
            {10'd0, lo_pix_valid, lo_pix_x, lo_pix_y, lo_pix_r, lo_pix_g, lo_pix_b, lo_frame_start,
             lo_locked, lo_sync_err_count, lo_frame_crc, lo_crc_valid});
      if (lo_pix_valid) begin
        if (pixq.size() == 0) unexpected("pixel");
        else check("pixel", {38'd0, lo_pix_x, lo_pix_y, lo_pix_r, lo_pix_g, lo_pix_b}, pixq.pop_front());
      end
      if (lo_frame_start) begin
        if (fsq.size() == 0) unexpected("frame_start");
        else check("frame_start_cycle", 64'(cyc), 64'(fsq.pop_front()));
      end
      if (lo_crc_valid) begin
        check("crc_fs_overlap", {63'd0, lo_frame_start}, 64'd0);
        got_crc.push_back(lo_frame_crc);
        if (crcq.size() == 0) unexpected("crc_valid");
        else check("frame_crc", {48'd0, lo_frame_crc}, {48'd0, crcq.pop_front()});
      end
      if (lo_locked && !lk_prev) begin
        if (riseq.size() == 0) unexpected("lock_rise");
        else check("lock_rise_cycle", 64'(cyc), 64'(riseq.pop_front()));
      end
      if (!lo_locked && lk_prev) begin
        if (fallq.size() == 0) unexpected("lock_fall");
        else check("lock_fall_cycle", 64'(cyc), 64'(fallq.pop_front()));
      end
    end
    lk_prev <= lo_locked;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_valid"}, {63'd0, lo_pix_valid}, 64'd0);
    check({tag, "_locked"}, {63'd0, lo_locked}, 64'd0);
    check({tag, "_frame_start"}, {63'd0, lo_frame_start}, 64'd0);
    check({tag, "_crc_valid"}, {63'd0, lo_crc_valid}, 64'd0);
    check({tag, "_sync_err_count"}, {56'd0, lo_sync_err_count}, 64'd0);
    check({tag, "_frame_crc"}, {48'd0, lo_frame_crc}, 64'd0);
    check({tag, "_xy"}, {44'd0, lo_pix_x, lo_pix_y}, 64'd0);
    check({tag, "_rgb"}, {58'd0, lo_pix_r, lo_pix_g, lo_pix_b}, 64'd0);
  endtask

  initial begin
    pmod_lo = 8'h88;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    frame(1'b1, 1'b0, 1'b0, 1'b0, -1, -1);   // first vsync: LINE -> FRAME
    frame(1'b1, 1'b0, 1'b0, 1'b1, -1, -1);   // second vsync: lock
    frame(1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
    frame(1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
    frame(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);   // all black
    frame(1'b0, 1'b0, 1'b0, 1'b0, 3, 2);     // black with one 0x3F pixel
    frame(1'b1, 1'b0, 1'b1, 1'b0, -1, -1);   // long line
    @(negedge clk);
    check("err_after_glitch", {56'd0, lo_sync_err_count}, 64'd1);
    frame(1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
    frame(1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
    frame(1'b1, 1'b1, 1'b0, 1'b0, -1, -1);   // vsync omitted
    @(negedge clk);
    check("err_after_missing_vs", {56'd0, lo_sync_err_count}, 64'd2);
    frame(1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
    frame(1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
    frame(1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
    for (int i = 0; i < 260; i++) begin
      frame(1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
      frame(1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
    end
    @(negedge clk);
    check("err_saturated", {56'd0, lo_sync_err_count}, 64'd255);
    frame(1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
    @(negedge clk);
    check("locked_before_reset", {63'd0, lo_locked}, 64'd1);

    @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");

    check("pix_queue_drained", 64'(pixq.size()), 64'd0);
    check("fs_queue_drained", 64'(fsq.size()), 64'd0);
    check("crc_queue_drained", 64'(crcq.size()), 64'd0);
    check("rise_queue_drained", 64'(riseq.size()), 64'd0);
    check("fall_queue_drained", 64'(fallq.size()), 64'd0);
    checks++;
    if (got_crc.size() >= 4 && got_crc[2] != got_crc[3]) passed++;
    else $display("FAIL crc_flip_differs: got %0d signatures, black/flipped must differ", got_crc.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
